// File: rtl/multi_debouncer.sv
// Multi-channel pushbutton debouncer: 2-flop sync, stability counter, edge pulses
// and a sticky request flag per channel. Channels are fully independent.

module multi_debouncer_lane #(
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic ack,
  output logic level,
  output logic rise,
  output logic fall,
  output logic req
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // Flip only after s2 has disagreed with the clean level for STABLE_CNT evaluations.
  assign flip = (s2 != level) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      req   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= flip & s2;
      fall <= flip & ~s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A fresh press beats a coincident ack so no press is lost.
      if (flip & s2)
        req <= 1'b1;
      else if (ack)
        req <= 1'b0;
    end
  end
endmodule

module multi_debouncer #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 20,
  parameter int STABLE_CNT  = 500000,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] req_ack
);
  logic [N_CH-1:0] raw;

  assign raw = ACTIVE_HIGH ? btn_in : ~btn_in;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    multi_debouncer_lane #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .ack   (req_ack[i]),
      .level (btn_level[i]),
      .rise  (btn_rise[i]),
      .fall  (btn_fall[i]),
      .req   (req[i])
    );
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: one active-high and one active-low instance,
// inputs driven and outputs checked on the falling clock edge.

module tb_multi_debouncer;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 3;
  localparam int STABLE = 4;

  logic            clk, rst_n;
  logic [N_CH-1:0] btn_h, ack_h, lvl_h, rise_h, fall_h, req_h;
  logic [N_CH-1:0] btn_l, ack_l, lvl_l, rise_l, fall_l, req_l;
  int checks = 0;
  int errors = 0;

  multi_debouncer #(.N_CH(N_CH), .CNT_W(CNT_W), .STABLE_CNT(STABLE), .ACTIVE_HIGH(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_h), .btn_level(lvl_h), .btn_rise(rise_h),
    .btn_fall(fall_h), .req(req_h), .req_ack(ack_h));

  multi_debouncer #(.N_CH(N_CH), .CNT_W(CNT_W), .STABLE_CNT(STABLE), .ACTIVE_HIGH(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_l), .btn_level(lvl_l), .btn_rise(rise_l),
    .btn_fall(fall_l), .req(req_l), .req_ack(ack_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    if (STABLE < 1 || STABLE > (1 << CNT_W) - 1)
      $fatal(1, "FAIL elab STABLE_CNT=%0d out of range for CNT_W=%0d", STABLE, CNT_W);
  end

  task automatic chk(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; btn_h = '0; ack_h = '0; btn_l = '1; ack_l = '0;
    tick(2);
    chk("rst_level_h", lvl_h, 4'b0000);
    chk("rst_rise_h",  rise_h, 4'b0000);
    chk("rst_fall_h",  fall_h, 4'b0000);
    chk("rst_req_h",   req_h, 4'b0000);
    chk("rst_level_l", lvl_l, 4'b0000);
    rst_n = 1'b1;
    tick(3);
    chk("idle_level_l", lvl_l, 4'b0000);

    // Clean press on ch0: level flips on edge 6
    btn_h = 4'b0001;
    tick(5);
    chk("press_e5_level", lvl_h, 4'b0000);
    tick(1);
    chk("press_e6_level", lvl_h, 4'b0001);
    chk("press_e6_rise",  rise_h, 4'b0001);
    chk("press_e6_req",   req_h, 4'b0001);
    chk("press_e6_fall",  fall_h, 4'b0000);
    tick(1);
    chk("press_e7_rise",  rise_h, 4'b0000);
    chk("press_e7_level", lvl_h, 4'b0001);

    // Release
    btn_h = 4'b0000;
    tick(5);
    chk("rel_e5_level", lvl_h, 4'b0001);
    chk("rel_e5_fall",  fall_h, 4'b0000);
    tick(1);
    chk("rel_e6_fall",  fall_h, 4'b0001);
    chk("rel_e6_level", lvl_h, 4'b0000);
    chk("rel_e6_req",   req_h, 4'b0001);
    tick(1);
    chk("rel_e7_fall",  fall_h, 4'b0000);
    ack_h = 4'b0001; tick(1); ack_h = '0;
    chk("ack0_req", req_h, 4'b0000);

    // Bounce on ch1
    for (int i = 0; i < 10; i++) begin
      btn_h[1] = (i % 2 == 0);
      tick(1);
      chk("bounce_level", lvl_h, 4'b0000);
      chk("bounce_rise",  rise_h, 4'b0000);
    end
    btn_h[1] = 1'b0;
    tick(6);
    chk("bounce_req", req_h, 4'b0000);

    // 3-cycle pulse is shorter than the stable time
    btn_h[1] = 1'b1; tick(3); btn_h[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("short_level", lvl_h, 4'b0000);
    end
    chk("short_req", req_h, 4'b0000);

    // Handshake on ch2
    btn_h[2] = 1'b1;
    tick(6);
    chk("hs_rise", rise_h, 4'b0100);
    chk("hs_req",  req_h, 4'b0100);
    ack_h[2] = 1'b1; tick(1); ack_h[2] = 1'b0;
    chk("hs_ack_clear", req_h, 4'b0000);
    ack_h[2] = 1'b1; tick(1); ack_h[2] = 1'b0;
    chk("hs_ack_idle", req_h, 4'b0000);
    btn_h[2] = 1'b0;
    tick(7);
    chk("hs_released", lvl_h, 4'b0000);
    btn_h[2] = 1'b1;
    tick(5);
    ack_h[2] = 1'b1; tick(1); ack_h[2] = 1'b0;
    chk("hs_set_wins_rise", rise_h, 4'b0100);
    chk("hs_set_wins_req",  req_h, 4'b0100);
    tick(1);
    chk("hs_set_wins_hold", req_h, 4'b0100);
    ack_h[2] = 1'b1; tick(1); ack_h[2] = 1'b0;
    chk("hs_final_clear", req_h, 4'b0000);
    btn_h[2] = 1'b0;
    tick(7);

    // Active-low instance, ch3
    btn_l = 4'b0111;
    tick(5);
    chk("al_e5_level", lvl_l, 4'b0000);
    tick(1);
    chk("al_e6_level", lvl_l, 4'b1000);
    chk("al_e6_rise",  rise_l, 4'b1000);
    chk("al_e6_req",   req_l, 4'b1000);

    // Reset mid-count with req[0] set and button held through reset
    btn_h[0] = 1'b1;
    tick(6);
    chk("mid_req_set", req_h, 4'b0001);
    btn_h[0] = 1'b0;
    tick(4);
    chk("mid_level_hold", lvl_h, 4'b0001);
    rst_n = 1'b0; btn_h[0] = 1'b1;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_level", lvl_h, 4'b0000);
    chk("mid_rst_req",   req_h, 4'b0000);
    chk("mid_rst_rise",  rise_h, 4'b0000);
    chk("mid_rst_fall",  fall_h, 4'b0000);
    chk("mid_rst_level_l", lvl_l, 4'b0000);
    chk("mid_rst_req_l",   req_l, 4'b0000);
    tick(5);
    chk("post_rst_e5", lvl_h, 4'b0000);
    tick(1);
    chk("post_rst_level", lvl_h, 4'b0001);
    chk("post_rst_rise",  rise_h, 4'b0001);
    chk("post_rst_req",   req_h, 4'b0001);
    chk("post_rst_level_l", lvl_l, 4'b1000);

    // Simultaneous ch0 + ch3
    btn_h = 4'b0000;
    tick(7);
    ack_h = 4'b0001; tick(1); ack_h = '0;
    chk("sim_pre_req", req_h, 4'b0000);
    btn_h = 4'b1001;
    tick(6);
    chk("sim_rise",  rise_h, 4'b1001);
    chk("sim_req",   req_h, 4'b1001);
    chk("sim_level", lvl_h, 4'b1001);
    ack_h = 4'b0001; tick(1); ack_h = '0;
    chk("sim_ack0_only", req_h, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button walk-request debouncer.
- Each channel of asynchronous pushbutton inputs is synchronised and counter-filtered so the clean level changes only after a configurable stable time.
- Each channel produces one-cycle press/release pulses and a sticky request flag that the traffic-light controller acknowledges.
- Sits between the board buttons and the controller FSM.

Parameters:
- N_CH, 4: number of independent button channels.
- CNT_W, 20: width of the per-channel stability counter.
- STABLE_CNT, 500000: consecutive cycles the synchronised input must differ from the clean level before the level flips. Legal range is 1 <= STABLE_CNT <= 2^CNT_W - 1.
- ACTIVE_HIGH, 1: 1 = a pressed button drives btn_in high; 0 = a pressed button drives btn_in low (input is inverted internally).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- btn_in  input  N_CH  raw asynchronous button inputs.
- btn_level  output  N_CH  debounced level; 1 = pressed.
- btn_rise  output  N_CH  one-cycle pulse on a debounced press.
- btn_fall  output  N_CH  one-cycle pulse on a debounced release.
- req  output  N_CH  sticky press request per channel.
- req_ack  input  N_CH  per-channel request clear from the consumer.

Behaviour:
- Reset (rst_n = 0 at a rising clk edge) clears every register: sync stages, counters, btn_level, btn_rise, btn_fall and req all go to 0. Reset is applied regardless of other inputs and may occur mid-count; the count is discarded.
- Polarity: raw = btn_in when ACTIVE_HIGH = 1, else ~btn_in. All later logic operates on raw (1 = pressed).
- Synchroniser: per-channel two-flop chain, raw -> s1 -> s2. No logic between the flops.
- Stability counter, per channel, evaluated every cycle:
  - s2 == btn_level: cnt <= 0.
  - s2 != btn_level and cnt < STABLE_CNT-1: cnt <= cnt+1.
  - s2 != btn_level and cnt == STABLE_CNT-1: btn_level <= s2, cnt <= 0.
- Any single cycle in which s2 matches btn_level restarts the count, so glitches shorter than STABLE_CNT cycles never reach btn_level.
- Latency: a clean step on btn_in first sampled at edge 1 produces the btn_level change at edge STABLE_CNT+2.
- Edge pulses are registered in the same cycle as the flip:
  - btn_rise <= flip & s2.
  - btn_fall <= flip & ~s2.
  - Each pulse is high for exactly one cycle, coincident with the first cycle of the new btn_level.
  - btn_rise and btn_fall are never both high on a channel.
- Request flag, per channel:
  - Set when btn_rise is generated.
  - Cleared when req_ack = 1 while req = 1.
  - If a set and req_ack occur in the same cycle, set wins and req stays 1, so a new press is never lost.
  - req_ack while req = 0 has no effect.
  - A repeated press while req = 1 leaves req at 1; presses are not counted.
- Channels are fully independent: no shared counters and no arbitration.
- A button held through reset release is treated as a new press: btn_level rises, btn_rise pulses and req sets STABLE_CNT+2 cycles after the first edge with rst_n = 1.
- Counter width must not overflow. cnt never exceeds STABLE_CNT-1.
- Bench adds an elaboration check: STABLE_CNT outside the legal range is an error.

Test Plan:
- Clean press and release (N_CH=4, STABLE_CNT=4, ACTIVE_HIGH=1): btn_in[0] 0->1 before edge 1 and held.
  - btn_level[0] = 1 after edge 6; btn_rise[0] high for that single cycle; req[0] = 1.
  - Releasing gives btn_fall[0] one cycle after 6 further edges.
- Bounce rejection: btn_in[1] toggles 1,0,1,0 each cycle for 10 cycles, then stays 0.
  - btn_level[1], btn_rise[1] and req[1] stay 0 throughout.
  - A 3-cycle pulse (shorter than STABLE_CNT=4) is also rejected.
- Request handshake:
  - Press ch2 so req[2] = 1; assert req_ack[2] for 1 cycle; req[2] = 0 the next cycle.
  - Pulse req_ack[2] again: no effect.
  - Drive req_ack[2] = 1 in the same cycle btn_rise[2] fires: req[2] remains 1.
- Active-low mode (ACTIVE_HIGH=0): btn_in idles at 1; drive btn_in[3] = 0.
  - btn_level[3] = 1 and btn_rise[3] pulse after 6 edges; other channels remain 0.
- Reset mid-operation:
  - Assert rst_n = 0 for one edge while ch0 cnt = 2 and req[0] = 1: all outputs are 0 the next cycle.
  - Keep btn_in[0] = 1 through reset: btn_level[0] rises 6 edges after release, and req[0] sets again.
- Simultaneous channels: press ch0 and ch3 in the same cycle.
  - Both btn_rise pulses occur in the same cycle.
  - ack of ch0 does not clear req[3].
